wb_arbiter: RTL and testbench

- Writeback arbiter for the RV32 core.
- Merges results from the ALU path and the load/store unit (LSU) into the register file's single write port (`we`, `rd_addr`, `rd_din`).
- Keeps a 32-entry pending-write scoreboard so the issue stage can stall on register hazards.
- Sits between the execute/memory stages and the register file; it is the only driver of the register file write port.

---
 rtl/wb_arbiter.sv | 103 ++++++++++
 tb/tb_wb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file write port
// and tracks pending writes. Define WB_BYPASS_EN to expose the write stage as a bypass.
module wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_din
`ifdef WB_BYPASS_EN
  ,
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve, starve_nxt;
  logic        force_alu;
  logic        grant;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic [31:0] busy_q, busy_nxt;

  assign force_alu = (starve >= LIMIT);
  assign lsu_ready = lsu_valid & ~force_alu;
  assign alu_ready = alu_valid & (~lsu_valid | force_alu);
  assign grant     = alu_ready | lsu_ready;
  assign win_rd    = alu_ready ? alu_rd   : lsu_rd;
  assign win_data  = alu_ready ? alu_data : lsu_data;

  always_comb begin
    starve_nxt = starve;
    if (!alu_valid || alu_ready)
      starve_nxt = '0;
    else if (starve != 4'hF)
      starve_nxt = starve + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve <= '0;
    else     starve <= starve_nxt;
  end

  // Writes to x0 are accepted but never reach the register file; address/data hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      we      <= 1'b0;
      rd_addr <= '0;
      rd_din  <= '0;
    end else begin
      we <= grant && (win_rd != '0);
      if (grant && (win_rd != '0)) begin
        rd_addr <= win_rd;
        rd_din  <= win_data;
      end
    end
  end

  // Set is applied after clear so a newer producer issuing on the commit edge keeps the bit.
  always_comb begin
    busy_nxt = busy_q;
    if (we)
      busy_nxt[rd_addr] = 1'b0;
    if (issue_valid && (issue_rd != '0))
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

`ifdef WB_BYPASS_EN
  assign byp_valid = we;
  assign byp_rd    = rd_addr;
  assign byp_data  = rd_din;
  assign rs1_busy  = busy_q[rs1_addr] & ~(we && (rd_addr == rs1_addr));
  assign rs2_busy  = busy_q[rs2_addr] & ~(we && (rd_addr == rs2_addr));
`else
  assign rs1_busy  = busy_q[rs1_addr];
  assign rs2_busy  = busy_q[rs2_addr];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a cycle-level reference model.
module tb_wb_arbiter;

  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_din;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`endif

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we(we), .rd_addr(rd_addr), .rd_din(rd_din)
`ifdef WB_BYPASS_EN
    , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        ear;
    logic        elr;
    logic        ewe;
    logic [4:0]  eaddr;
    logic [31:0] edin;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the register file port and scoreboard should look like.
  bit [31:0]   m_busy;
  int          m_starve;
  bit          m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_alu_granted;
  bit          m_lsu_granted;

  function automatic stim_t idle(input logic [4:0] rs1);
    stim_t s;
    s = '{rst: 1'b0, av: 1'b0, ard: '0, ad: '0, lv: 1'b0, lrd: '0, ld: '0,
          iv: 1'b0, ird: '0, rs1: rs1, rs2: '0};
    return s;
  endfunction

  function automatic vec_t mv(input stim_t s, input logic ear, input logic elr,
                              input logic ewe, input logic [4:0] eaddr, input logic [31:0] edin);
    vec_t v;
    v.s = s; v.ear = ear; v.elr = elr; v.ewe = ewe; v.eaddr = eaddr; v.edin = edin;
    return v;
  endfunction

  task automatic apply(input stim_t s);
    rst = s.rst;
    alu_valid = s.av; alu_rd = s.ard; alu_data = s.ad;
    lsu_valid = s.lv; lsu_rd = s.lrd; lsu_data = s.ld;
    issue_valid = s.iv; issue_rd = s.ird;
    rs1_addr = s.rs1; rs2_addr = s.rs2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef WB_BYPASS_EN
    if (m_we && m_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic check_model();
    bit force_alu;
    force_alu = (m_starve >= int'(LIMIT));
    chk("alu_ready", alu_ready, alu_valid && (!lsu_valid || force_alu));
    chk("lsu_ready", lsu_ready, lsu_valid && !force_alu);
    chk("we", we, m_we);
    chk("rd_addr", rd_addr, m_addr);
    chk("rd_din", rd_din, m_data);
    chk("rs1_busy", rs1_busy, exp_busy(rs1_addr));
    chk("rs2_busy", rs2_busy, exp_busy(rs2_addr));
`ifdef WB_BYPASS_EN
    chk("byp_valid", byp_valid, m_we);
    chk("byp_rd", byp_rd, m_addr);
    chk("byp_data", byp_data, m_data);
`endif
  endtask

  function automatic void model_update();
    bit force_alu, g_alu, g_lsu, old_we;
    logic [4:0] old_addr, wrd;
    if (rst) begin
      m_busy = '0; m_starve = 0; m_we = 0; m_addr = '0; m_data = '0;
      m_alu_granted = 0; m_lsu_granted = 0;
      return;
    end
    force_alu = (m_starve >= int'(LIMIT));
    g_alu = alu_valid && (!lsu_valid || force_alu);
    g_lsu = lsu_valid && !force_alu;
    m_alu_granted = g_alu;
    m_lsu_granted = g_lsu;
    old_we = m_we;
    old_addr = m_addr;
    m_we = 0;
    if (g_alu || g_lsu) begin
      wrd = g_alu ? alu_rd : lsu_rd;
      if (wrd != 5'd0) begin
        m_we = 1;
        m_addr = wrd;
        m_data = g_alu ? alu_data : lsu_data;
      end
    end
    if (old_we) m_busy[old_addr] = 1'b0;
    if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
    if (!alu_valid || g_alu) m_starve = 0;
    else if (m_starve < 15) m_starve = m_starve + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input stim_t s);
    apply(s);
    #1;
    check_model();
  endtask

  initial begin
    vec_t  tbl[$];
    stim_t s;
    logic [4:0]  paddr;
    logic [31:0] pdin;
    bit          pwe;

    // Bring registers out of X before any comparison.
    s = idle(5'd0); s.rst = 1'b1;
    apply(s);
    tick();

    // Reset: readies follow valids, transfer discarded.
    s = idle(5'd0); s.rst = 1'b1; s.av = 1; s.ard = 5'd5; s.ad = 32'hDEAD_BEEF;
    s.lv = 1; s.lrd = 5'd6; s.ld = 32'hCAFE_F00D;
    tbl.push_back(mv(s, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0));
    s = idle(5'd0); s.rst = 1'b1;
    tbl.push_back(mv(s, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
    // Single ALU write to x5.
    s = idle(5'd0); s.av = 1; s.ard = 5'd5; s.ad = 32'h1234_5678;
    tbl.push_back(mv(s, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
    tbl.push_back(mv(idle(5'd0), 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678));
    tbl.push_back(mv(idle(5'd0), 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234_5678));
    // Write to x0 is accepted and dropped; port holds previous address/data.
    s = idle(5'd0); s.av = 1; s.ard = 5'd0; s.ad = 32'hFFFF_FFFF;
    tbl.push_back(mv(s, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234_5678));
    tbl.push_back(mv(idle(5'd0), 1'b0, 1'b0, 1'b0, 5'd5, 32'h1234_5678));
    // Both sources valid: four LSU grants then one forced ALU grant, repeating.
    pwe = 0; paddr = 5'd5; pdin = 32'h1234_5678;
    for (int c = 0; c < 11; c++) begin
      bit alu_turn;
      alu_turn = ((c % 5) == 4);
      s = idle(5'd0); s.av = 1; s.ard = 5'd1; s.ad = 32'hA1;
      s.lv = 1; s.lrd = 5'd2; s.ld = 32'hB2;
      tbl.push_back(mv(s, alu_turn, !alu_turn, pwe, paddr, pdin));
      pwe = 1;
      paddr = alu_turn ? 5'd1 : 5'd2;
      pdin  = alu_turn ? 32'hA1 : 32'hB2;
    end

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s);
      chk($sformatf("vec%0d_alu_ready", i), alu_ready, tbl[i].ear);
      chk($sformatf("vec%0d_lsu_ready", i), lsu_ready, tbl[i].elr);
      chk($sformatf("vec%0d_we", i), we, tbl[i].ewe);
      chk($sformatf("vec%0d_rd_addr", i), rd_addr, tbl[i].eaddr);
      chk($sformatf("vec%0d_rd_din", i), rd_din, tbl[i].edin);
      chk($sformatf("vec%0d_rs1_busy_x0", i), rs1_busy, 1'b0);
      tick();
    end

    // Issue x7, LSU writes x7 five cycles later.
    s = idle(5'd7); s.iv = 1; s.ird = 5'd7;
    step(s); chk("t2_busy_at_issue", rs1_busy, 1'b0); tick();
    for (int k = 0; k < 5; k++) begin
      step(idle(5'd7)); chk("t2_busy_pending", rs1_busy, 1'b1); tick();
    end
    s = idle(5'd7); s.lv = 1; s.lrd = 5'd7; s.ld = 32'h0000_7777;
    step(s); chk("t2_lsu_ready", lsu_ready, 1'b1); chk("t2_busy_grant", rs1_busy, 1'b1); tick();
    step(idle(5'd7));
    chk("t2_we", we, 1'b1); chk("t2_rd_addr", rd_addr, 5'd7); chk("t2_rd_din", rd_din, 32'h7777);
`ifdef WB_BYPASS_EN
    chk("t2_busy_commit", rs1_busy, 1'b0);
`else
    chk("t2_busy_commit", rs1_busy, 1'b1);
`endif
    tick();
    step(idle(5'd7)); chk("t2_busy_after", rs1_busy, 1'b0); tick();

    // Re-issue of x9 on the edge its older write commits: set wins.
    s = idle(5'd9); s.iv = 1; s.ird = 5'd9; step(s); tick();
    s = idle(5'd9); s.lv = 1; s.lrd = 5'd9; s.ld = 32'h9999; step(s); tick();
    s = idle(5'd9); s.iv = 1; s.ird = 5'd9;
    step(s); chk("t5_we", we, 1'b1); chk("t5_rd_addr", rd_addr, 5'd9); tick();
    for (int k = 0; k < 3; k++) begin
      step(idle(5'd9)); chk("t5_busy_kept", rs1_busy, 1'b1); tick();
    end

    // Reset while a write to x3 is in flight and x3 is pending.
    s = idle(5'd3); s.iv = 1; s.ird = 5'd3; step(s); tick();
    s = idle(5'd3); s.av = 1; s.ard = 5'd3; s.ad = 32'h3333; step(s); tick();
    s = idle(5'd3); s.rst = 1;
    step(s); chk("t6_we_before", we, 1'b1); chk("t6_addr_before", rd_addr, 5'd3); tick();
    step(idle(5'd3));
    chk("t6_we", we, 1'b0); chk("t6_rd_addr", rd_addr, 5'd0);
    chk("t6_rd_din", rd_din, 32'h0); chk("t6_busy3", rs1_busy, 1'b0);
    tick();

    // Randomized traffic; sources hold rd/data while waiting for ready.
    s = idle(5'd0);
    m_alu_granted = 0; m_lsu_granted = 0;
    for (int i = 0; i < 4000; i++) begin
      if (!s.av || m_alu_granted || s.rst) begin
        s.av  = ($urandom_range(0, 3) != 0);
        s.ard = 5'($urandom_range(0, 7));
        s.ad  = $urandom;
      end
      if (!s.lv || m_lsu_granted || s.rst) begin
        s.lv  = ($urandom_range(0, 3) != 0);
        s.lrd = 5'($urandom_range(0, 7));
        s.ld  = $urandom;
      end
      s.rst = ($urandom_range(0, 99) == 0);
      s.iv  = ($urandom_range(0, 1) != 0);
      s.ird = 5'($urandom_range(0, 7));
      s.rs1 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      s.rs2 = 5'($urandom_range(0, 7));
      step(s);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
